// File: rtl/ysyx_22050854_cpu_fsm.sv
// ysyx_22050854 multi-cycle sequencer.
// Handshaked fetch/decode/exec/mem/wb FSM owning pc, inst_q and instret.
module ysyx_22050854_cpu_fsm #(
    parameter int unsigned XLEN     = 64,
    parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            if_req_valid,
    output logic [XLEN-1:0] if_req_addr,
    input  logic            if_req_ready,
    input  logic            if_rsp_valid,
    input  logic [31:0]     if_rsp_inst,
    output logic [31:0]     inst_q,
    input  logic            dec_regwr,
    input  logic            dec_load,
    input  logic            dec_store,
    input  logic            dec_ebreak,
    input  logic [XLEN-1:0] next_pc,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    output logic            rf_wen,
    output logic [XLEN-1:0] pc,
    output logic            retire,
    output logic [63:0]     instret,
    output logic            halted,
    output logic            fault
);

    typedef enum logic [2:0] {
        S_FETCH_REQ,
        S_FETCH_WAIT,
        S_DECODE,
        S_EXEC,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_WB,
        S_HALT
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [63:0]     instret_q;
    logic [63:0]     instret_d;
    logic            if_req_valid_q;
    logic            mem_req_valid_q;
    logic            rf_wen_q;
    logic            retire_q;
    logic            halted_q;
    logic            fault_q;

    // Strobes and requests are forced low while reset is held.
    assign if_req_valid  = if_req_valid_q & ~rst;
    assign mem_req_valid = mem_req_valid_q & ~rst;
    assign rf_wen        = rf_wen_q & ~rst;
    assign retire        = retire_q & ~rst;
    assign if_req_addr   = pc_q;
    assign pc            = pc_q;
    assign instret       = instret_q;
    assign halted        = halted_q;
    assign fault         = fault_q;
    assign instret_d     = instret_q + 64'd1;

    // Sequencer: state, architectural state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_FETCH_REQ;
            pc_q            <= RESET_PC[XLEN-1:0];
            inst_q          <= 32'd0;
            instret_q       <= 64'd0;
            if_req_valid_q  <= 1'b1;
            mem_req_valid_q <= 1'b0;
            rf_wen_q        <= 1'b0;
            retire_q        <= 1'b0;
            halted_q        <= 1'b0;
            fault_q         <= 1'b0;
        end else begin
            rf_wen_q <= 1'b0;
            retire_q <= 1'b0;
            if (retire_q) begin
                instret_q <= instret_d;
            end
            unique case (state_q)
                S_FETCH_REQ: begin
                    if (if_req_valid_q && if_req_ready) begin
                        if_req_valid_q <= 1'b0;
                        state_q        <= S_FETCH_WAIT;
                    end
                end
                S_FETCH_WAIT: begin
                    if (if_rsp_valid) begin
                        inst_q  <= if_rsp_inst;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    if (dec_ebreak) begin
                        retire_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if (dec_load || dec_store) begin
                        mem_req_valid_q <= 1'b1;
                        state_q         <= S_MEM_REQ;
                    end else begin
                        rf_wen_q <= dec_regwr & ~dec_store;
                        retire_q <= 1'b1;
                        state_q  <= S_WB;
                    end
                end
                S_MEM_REQ: begin
                    if (mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= S_MEM_WAIT;
                    end
                end
                S_MEM_WAIT: begin
                    if (mem_rsp_valid) begin
                        rf_wen_q <= dec_regwr & ~dec_store;
                        retire_q <= 1'b1;
                        state_q  <= S_WB;
                    end
                end
                S_WB: begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_q           <= next_pc;
                        if_req_valid_q <= 1'b1;
                        state_q        <= S_FETCH_REQ;
                    end else begin
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050854_cpu_fsm.sv
// Bench for ysyx_22050854_cpu_fsm.
// Transaction-level model of pc/instret with randomized handshake delays.
module tb_ysyx_22050854_cpu_fsm;

    localparam logic [63:0] RPC = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req_valid;
    logic [63:0] if_req_addr;
    logic        if_req_ready;
    logic        if_rsp_valid;
    logic [31:0] if_rsp_inst;
    logic [31:0] inst_q;
    logic        dec_regwr;
    logic        dec_load;
    logic        dec_store;
    logic        dec_ebreak;
    logic [63:0] next_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic        rf_wen;
    logic [63:0] pc;
    logic        retire;
    logic [63:0] instret;
    logic        halted;
    logic        fault;

    always #5 clk = ~clk;

    ysyx_22050854_cpu_fsm #(
        .XLEN(64),
        .RESET_PC(RPC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req_valid(if_req_valid),
        .if_req_addr(if_req_addr),
        .if_req_ready(if_req_ready),
        .if_rsp_valid(if_rsp_valid),
        .if_rsp_inst(if_rsp_inst),
        .inst_q(inst_q),
        .dec_regwr(dec_regwr),
        .dec_load(dec_load),
        .dec_store(dec_store),
        .dec_ebreak(dec_ebreak),
        .next_pc(next_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid),
        .rf_wen(rf_wen),
        .pc(pc),
        .retire(retire),
        .instret(instret),
        .halted(halted),
        .fault(fault)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_ret_seen = 0;
    int n_ret_exp  = 0;
    logic [63:0] pc_m;
    logic [63:0] instret_m;

    always @(negedge clk) begin
        if (retire === 1'b1) n_ret_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic quiet(input string tag);
        chk({tag, "_retire"}, retire, 0);
        chk({tag, "_rfwen"}, rf_wen, 0);
    endtask

    task automatic fetch_strays();
        mem_req_ready = 1'($urandom % 2);
        mem_rsp_valid = 1'($urandom % 2);
    endtask

    task automatic mem_strays();
        if_req_ready = 1'($urandom % 2);
        if_rsp_valid = 1'($urandom % 2);
        if_rsp_inst  = $urandom;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_strays();
        fetch_strays();
        @(negedge clk);
        @(negedge clk);
        chk("rst_ifv", if_req_valid, 0);
        chk("rst_memv", mem_req_valid, 0);
        quiet("rst");
        chk("rst_pc", pc, RPC);
        chk("rst_instret", instret, 0);
        chk("rst_inst", inst_q, 0);
        chk("rst_halted", halted, 0);
        chk("rst_fault", fault, 0);
        rst = 1'b0;
        if_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        pc_m = RPC;
        instret_m = 64'd0;
        #1;
        chk("post_rst_ifv", if_req_valid, 1);
        @(negedge clk);
    endtask

    // kind: 0 alu, 1 load, 2 store, 3 ebreak
    task automatic run_instr(input int kind, input bit regwr,
                             input int rd, input int sd,
                             input int md, input int nd,
                             input logic [63:0] np, input bit abort);
        logic [31:0] ins;
        bit mem;
        ins = $urandom;
        mem = (kind == 1) || (kind == 2);
        dec_regwr  = regwr;
        dec_load   = (kind == 1);
        dec_store  = (kind == 2);
        dec_ebreak = (kind == 3);
        next_pc    = np;
        for (int i = 0; i < rd; i++) begin
            chk("fr_wait_v", if_req_valid, 1);
            chk("fr_wait_addr", if_req_addr, pc_m);
            quiet("fr_wait");
            if_req_ready = 1'b0;
            if_rsp_valid = 1'($urandom % 2);
            if_rsp_inst  = $urandom;
            fetch_strays();
            @(negedge clk);
        end
        chk("fr_v", if_req_valid, 1);
        chk("fr_addr", if_req_addr, pc_m);
        chk("fr_memv", mem_req_valid, 0);
        quiet("fr");
        if_req_ready = 1'b1;
        if_rsp_valid = 1'($urandom % 2);
        fetch_strays();
        @(negedge clk);
        if_req_ready = 1'b0;
        for (int i = 0; i < sd; i++) begin
            chk("fw_v", if_req_valid, 0);
            quiet("fw");
            if_rsp_valid = 1'b0;
            fetch_strays();
            @(negedge clk);
        end
        chk("fw_v", if_req_valid, 0);
        if_rsp_valid = 1'b1;
        if_rsp_inst  = ins;
        fetch_strays();
        @(negedge clk);
        chk("dec_inst", inst_q, ins);
        chk("dec_v", if_req_valid, 0);
        quiet("dec");
        mem_strays();
        fetch_strays();
        @(negedge clk);
        chk("ex_inst", inst_q, ins);
        chk("ex_memv", mem_req_valid, 0);
        quiet("ex");
        mem_strays();
        fetch_strays();
        @(negedge clk);
        if (kind == 3) begin
            chk("ebrk_retire", retire, 1);
            chk("ebrk_rfwen", rf_wen, 0);
            chk("ebrk_halted0", halted, 0);
            chk("ebrk_ifv", if_req_valid, 0);
            chk("ebrk_pc", pc, pc_m);
            instret_m = instret_m + 64'd1;
            n_ret_exp++;
            mem_strays();
            fetch_strays();
            @(negedge clk);
            chk("ebrk_halted", halted, 1);
            chk("ebrk_fault", fault, 0);
            quiet("ebrk_after");
            chk("ebrk_instret", instret, instret_m);
            chk("ebrk_pc2", pc, pc_m);
            return;
        end
        if (mem) begin
            for (int i = 0; i < md; i++) begin
                chk("mr_wait_v", mem_req_valid, 1);
                quiet("mr_wait");
                mem_req_ready = 1'b0;
                mem_rsp_valid = 1'($urandom % 2);
                mem_strays();
                @(negedge clk);
            end
            chk("mr_v", mem_req_valid, 1);
            quiet("mr");
            mem_req_ready = 1'b1;
            mem_rsp_valid = 1'($urandom % 2);
            mem_strays();
            @(negedge clk);
            mem_req_ready = 1'b0;
            if (abort) begin
                rst = 1'b1;
                mem_rsp_valid = 1'b1;
                @(negedge clk);
                quiet("abort");
                chk("abort_pc", pc, RPC);
                chk("abort_instret", instret, 0);
                chk("abort_inst", inst_q, 0);
                chk("abort_memv", mem_req_valid, 0);
                rst = 1'b0;
                mem_rsp_valid = 1'b1;
                if_req_ready = 1'b0;
                pc_m = RPC;
                instret_m = 64'd0;
                @(negedge clk);
                chk("abort_ifv", if_req_valid, 1);
                chk("abort_addr", if_req_addr, RPC);
                chk("abort_memv2", mem_req_valid, 0);
                quiet("abort2");
                mem_rsp_valid = 1'b0;
                return;
            end
            for (int i = 0; i < nd; i++) begin
                chk("mw_v", mem_req_valid, 0);
                quiet("mw");
                mem_rsp_valid = 1'b0;
                mem_strays();
                @(negedge clk);
            end
            mem_rsp_valid = 1'b1;
            mem_strays();
            @(negedge clk);
            mem_rsp_valid = 1'b0;
        end
        chk("wb_retire", retire, 1);
        chk("wb_rfwen", rf_wen, regwr & (kind != 2));
        chk("wb_inst", inst_q, ins);
        chk("wb_ifv", if_req_valid, 0);
        instret_m = instret_m + 64'd1;
        n_ret_exp++;
        mem_strays();
        fetch_strays();
        @(negedge clk);
        if (np[1:0] == 2'b00) begin
            pc_m = np;
            chk("nx_addr", if_req_addr, pc_m);
            chk("nx_ifv", if_req_valid, 1);
            chk("nx_instret", instret, instret_m);
            chk("nx_halted", halted, 0);
            quiet("nx");
        end else begin
            chk("mis_fault", fault, 1);
            chk("mis_halted", halted, 1);
            chk("mis_pc", pc, pc_m);
            chk("mis_instret", instret, instret_m);
            quiet("mis");
        end
    endtask

    task automatic halt_quiet(input int n);
        for (int i = 0; i < n; i++) begin
            mem_strays();
            fetch_strays();
            @(negedge clk);
            chk("h_ifv", if_req_valid, 0);
            chk("h_memv", mem_req_valid, 0);
            quiet("h");
            chk("h_halted", halted, 1);
            chk("h_pc", pc, pc_m);
            chk("h_instret", instret, instret_m);
        end
    endtask

    int          kind;
    bit          ab;
    logic [63:0] np;

    initial begin
        rst = 1'b1;
        if_req_ready = 1'b0;
        if_rsp_valid = 1'b0;
        if_rsp_inst = 32'd0;
        dec_regwr = 1'b0;
        dec_load = 1'b0;
        dec_store = 1'b0;
        dec_ebreak = 1'b0;
        next_pc = 64'd0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        @(negedge clk);

        // addi, load with waits, ebreak at 0x80000008
        do_reset();
        run_instr(0, 1, 0, 0, 0, 0, pc_m + 64'd4, 0);
        chk("addi_addr", if_req_addr, 64'h8000_0004);
        run_instr(1, 1, 0, 0, 2, 1, pc_m + 64'd4, 0);
        chk("ebrk_at", if_req_addr, 64'h8000_0008);
        run_instr(3, 0, 0, 0, 0, 0, pc_m + 64'd4, 0);
        chk("ebrk_cnt", instret, 64'd3);
        halt_quiet(20);

        // fetch waits, store, misaligned branch
        do_reset();
        run_instr(0, 1, 3, 2, 0, 0, pc_m + 64'd4, 0);
        run_instr(2, 1, 0, 0, 1, 1, RPC + 64'd2, 0);
        chk("mis_pc_val", pc, 64'h8000_0004);
        halt_quiet(4);

        // abort mid MEM_WAIT, then continue
        do_reset();
        run_instr(0, 1, 0, 0, 0, 0, pc_m + 64'd8, 0);
        run_instr(1, 1, 1, 0, 1, 0, pc_m + 64'd4, 1);
        run_instr(0, 1, 0, 1, 0, 0, pc_m + 64'd4, 0);

        // instret wrap
        force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.instret_q;
        instret_m = 64'hFFFF_FFFF_FFFF_FFFE;
        chk("wrap_pre", instret, instret_m);
        run_instr(0, 0, 0, 0, 0, 0, pc_m + 64'd4, 0);
        run_instr(0, 1, 0, 0, 0, 0, pc_m + 64'd4, 0);
        chk("wrap_zero", instret, 64'd0);

        // random episodes
        for (int e = 0; e < 6; e++) begin
            do_reset();
            for (int k = 0; k < 12; k++) begin
                kind = $urandom_range(0, 2);
                if ($urandom % 3 == 0)
                    np = {32'h8000_0000, $urandom} & ~64'h3;
                else
                    np = pc_m + 64'({$urandom_range(0, 7), 2'b00});
                ab = (kind == 1) && ($urandom % 6 == 0);
                run_instr(kind, 1'($urandom % 2), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), np, ab);
            end
            if ($urandom % 2 == 0) begin
                run_instr(3, 0, $urandom_range(0, 2), 0, 0, 0,
                          pc_m + 64'd4, 0);
            end else begin
                np = pc_m + 64'($urandom_range(1, 3));
                run_instr(0, 1, 0, $urandom_range(0, 2), 0, 0, np, 0);
            end
            halt_quiet(6);
        end

        @(negedge clk);
        chk("retire_total", 64'(n_ret_seen), 64'(n_ret_exp));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
